// File: rtl/bmu_pkg.sv
// Shared types for the bit-manipulation unit pipe.
// Provides the one-hot op select and op count.
package bmu_pkg;

   localparam int BMU_NUM_OPS = 12;

   typedef struct packed {
      logic add;
      logic sub;
      logic slt;
      logic min;
      logic land;
      logic lxor;
      logic sll;
      logic sra;
      logic rol;
      logic clz;
      logic cpop;
      logic bext;
   } bmu_op_t;

endpackage

// File: rtl/bmu_fifo.sv
// Result FIFO: push/pop/flush, full/empty/count, plus
// full_nxt (full as it will be after this edge).
module bmu_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4,
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic         clk,
   input  logic         rst_l,
   input  logic         push,
   input  logic         pop,
   input  logic         flush,
   input  logic [W-1:0] wdata,
   output logic [W-1:0] rdata,
   output logic         full,
   output logic         full_nxt,
   output logic         empty,
   output logic [CW-1:0] count
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nxt;
   logic          wr_en;
   logic          rd_en;

   assign full     = (cnt == CW'(DEPTH));
   assign empty    = (cnt == '0);
   assign count    = cnt;
   assign wr_en    = push & ~flush & ~full;
   assign rd_en    = pop & ~flush & ~empty;
   assign cnt_nxt  = flush ? '0
                   : cnt + CW'(wr_en) - CW'(rd_en);
   assign full_nxt = (cnt_nxt == CW'(DEPTH));
   // Gating with empty keeps the head at zero in reset.
   assign rdata    = empty ? '0 : mem[rptr];

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         wptr <= '0;
         rptr <= '0;
         cnt  <= '0;
      end else if (flush) begin
         wptr <= '0;
         rptr <= '0;
         cnt  <= '0;
      end else begin
         wptr <= wptr + AW'(wr_en);
         rptr <= rptr + AW'(rd_en);
         cnt  <= cnt_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wptr] <= wdata;
   end

endmodule

// File: rtl/bmu_pipe.sv
// Bit-manipulation unit: combinational datapath feeding a
// result FIFO. Ports: valid/ready request side (ap, a_in,
// b_in, tag_in), valid/ready result side (result_out,
// error_out, tag_out), flush_in, count_out.
module bmu_pipe
   import bmu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4,
   parameter int TAG_W = 4
) (
   input  logic                    clk,
   input  logic                    rst_l,
   input  logic                    valid_in,
   output logic                    ready_out,
   input  bmu_op_t                 ap,
   input  logic signed [WIDTH-1:0] a_in,
   input  logic signed [WIDTH-1:0] b_in,
   input  logic [TAG_W-1:0]        tag_in,
   output logic                    valid_out,
   input  logic                    ready_in,
   output logic [WIDTH-1:0]        result_out,
   output logic                    error_out,
   output logic [TAG_W-1:0]        tag_out,
   input  logic                    flush_in,
   output logic [$clog2(DEPTH):0]  count_out
);

   localparam int SW = $clog2(WIDTH);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam int EW = WIDTH + 1 + TAG_W;

   // Returns {error, result}.
   function automatic logic [WIDTH:0] exec(
      input bmu_op_t                 op,
      input logic signed [WIDTH-1:0] a,
      input logic signed [WIDTH-1:0] b
   );
      logic [WIDTH-1:0] r;
      logic             e;
      logic [SW-1:0]    sh;
      logic             seen;
      int               n;
      r    = '0;
      e    = 1'b0;
      sh   = b[SW-1:0];
      seen = 1'b0;
      n    = 0;
      if (!$onehot(op)) begin
         e = 1'b1;
      end else begin
         unique case (1'b1)
            op.add: begin
               r = a + b;
               e = (a[WIDTH-1] == b[WIDTH-1]) &&
                   (r[WIDTH-1] != a[WIDTH-1]);
            end
            op.sub: begin
               r = a - b;
               e = (a[WIDTH-1] != b[WIDTH-1]) &&
                   (r[WIDTH-1] != a[WIDTH-1]);
            end
            op.slt:  r = WIDTH'(a < b);
            op.min:  r = (a < b) ? a : b;
            op.land: r = a & b;
            op.lxor: r = a ^ b;
            op.sll:  r = a << sh;
            op.sra:  r = a >>> sh;
            // sh==0 shifts right by WIDTH, which yields 0.
            op.rol:  r = (a << sh) | (a >> (WIDTH - int'(sh)));
            op.clz: begin
               for (int i = WIDTH - 1; i >= 0; i--) begin
                  if (a[i]) seen = 1'b1;
                  else if (!seen) n = n + 1;
               end
               r = WIDTH'(n);
            end
            op.cpop: begin
               for (int i = 0; i < WIDTH; i++)
                  n = n + int'(a[i]);
               r = WIDTH'(n);
            end
            op.bext: r = WIDTH'(a[sh]);
            default: ;
         endcase
      end
      return {e, r};
   endfunction

   logic [WIDTH-1:0] x_res;
   logic             x_err;
   logic [EW-1:0]    wdata;
   logic [EW-1:0]    head;
   logic             push;
   logic             pop;
   logic             full;
   logic             full_nxt;
   logic             empty;
   logic             ready_q;

   always_comb begin
      {x_err, x_res} = exec(ap, a_in, b_in);
   end

   assign wdata     = {x_res, x_err, tag_in};
   assign push      = valid_in & ready_q & ~flush_in & ~full;
   assign pop       = ~empty & ready_in;
   assign valid_out = ~empty;
   assign ready_out = ready_q;
   assign {result_out, error_out, tag_out} = head;

   bmu_fifo #(
      .W     (EW),
      .DEPTH (DEPTH),
      .CW    (CW)
   ) u_fifo (
      .clk      (clk),
      .rst_l    (rst_l),
      .push     (push),
      .pop      (pop),
      .flush    (flush_in),
      .wdata    (wdata),
      .rdata    (head),
      .full     (full),
      .full_nxt (full_nxt),
      .empty    (empty),
      .count    (count_out)
   );

   // Registered so ready_in never reaches ready_out combinationally.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) ready_q <= 1'b0;
      else        ready_q <= ~full_nxt;
   end

endmodule

// File: tb/tb_bmu_pipe.sv
// Scoreboard bench for bmu_pipe: 32-bit and 8-bit instances,
// directed vectors, backpressure, flush and reset cases.
module tb_bmu_pipe;
   import bmu_pkg::*;

   typedef struct {
      logic [63:0] res;
      logic        err;
      logic [3:0]  tag;
   } exp_t;

   localparam int ADD = 0, SUB = 1, SLT = 2, MIN = 3, LAND = 4,
                  LXOR = 5, SLL = 6, SRA = 7, ROL = 8, CLZ = 9,
                  CPOP = 10, BEXT = 11;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int passes = 0;
   exp_t q32[$];
   exp_t q8[$];
   exp_t m32;
   exp_t m8;

   logic               rst_l, valid_in, ready_out, valid_out;
   logic               ready_in, error_out, flush_in;
   bmu_op_t            ap;
   logic signed [31:0] a_in, b_in;
   logic [3:0]         tag_in, tag_out;
   logic [31:0]        result_out;
   logic [2:0]         count_out;

   logic               rst8_l, valid8_in, ready8_out, valid8_out;
   logic               ready8_in, error8_out, flush8_in;
   bmu_op_t            ap8;
   logic signed [7:0]  a8_in, b8_in;
   logic [3:0]         tag8_in, tag8_out;
   logic [7:0]         result8_out;
   logic [2:0]         count8_out;

   bmu_pipe #(.WIDTH(32), .DEPTH(4), .TAG_W(4)) u32 (
      .clk(clk), .rst_l(rst_l), .valid_in(valid_in),
      .ready_out(ready_out), .ap(ap), .a_in(a_in), .b_in(b_in),
      .tag_in(tag_in), .valid_out(valid_out), .ready_in(ready_in),
      .result_out(result_out), .error_out(error_out),
      .tag_out(tag_out), .flush_in(flush_in), .count_out(count_out)
   );

   bmu_pipe #(.WIDTH(8), .DEPTH(4), .TAG_W(4)) u8 (
      .clk(clk), .rst_l(rst8_l), .valid_in(valid8_in),
      .ready_out(ready8_out), .ap(ap8), .a_in(a8_in), .b_in(b8_in),
      .tag_in(tag8_in), .valid_out(valid8_out), .ready_in(ready8_in),
      .result_out(result8_out), .error_out(error8_out),
      .tag_out(tag8_out), .flush_in(flush8_in), .count_out(count8_out)
   );

   function automatic bmu_op_t mk_op(input int i);
      logic [11:0] v;
      v = 12'd1 << (11 - i);
      return bmu_op_t'(v);
   endfunction

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   always @(negedge clk) begin
      if (rst_l && valid_out && ready_in) begin
         if (q32.size() == 0) begin
            checks++;
            $display("FAIL mon32: unexpected tag %0d got, none expected",
                     tag_out);
         end else begin
            m32 = q32.pop_front();
            chk("res32", 64'(result_out), m32.res);
            chk("err32", 64'(error_out), 64'(m32.err));
            chk("tag32", 64'(tag_out), 64'(m32.tag));
         end
      end
   end

   always @(negedge clk) begin
      if (rst8_l && valid8_out && ready8_in) begin
         if (q8.size() == 0) begin
            checks++;
            $display("FAIL mon8: unexpected tag %0d got, none expected",
                     tag8_out);
         end else begin
            m8 = q8.pop_front();
            chk("res8", 64'(result8_out), m8.res);
            chk("err8", 64'(error8_out), 64'(m8.err));
            chk("tag8", 64'(tag8_out), 64'(m8.tag));
         end
      end
   end

   task automatic send32(input bmu_op_t o, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] t,
                         input logic [31:0] er, input logic ee);
      int n = 0;
      ap = o; a_in = a; b_in = b; tag_in = t; valid_in = 1'b1;
      @(negedge clk);
      while (!ready_out && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!ready_out) begin
         chk("send32_timeout", 64'(ready_out), 64'd1);
         valid_in = 1'b0;
         return;
      end
      q32.push_back('{res: 64'(er), err: ee, tag: t});
      @(posedge clk);
      #1 valid_in = 1'b0;
   endtask

   task automatic send8(input bmu_op_t o, input logic [7:0] a,
                        input logic [7:0] b, input logic [3:0] t,
                        input logic [7:0] er, input logic ee);
      int n = 0;
      ap8 = o; a8_in = a; b8_in = b; tag8_in = t; valid8_in = 1'b1;
      @(negedge clk);
      while (!ready8_out && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!ready8_out) begin
         chk("send8_timeout", 64'(ready8_out), 64'd1);
         valid8_in = 1'b0;
         return;
      end
      q8.push_back('{res: 64'(er), err: ee, tag: t});
      @(posedge clk);
      #1 valid8_in = 1'b0;
   endtask

   task automatic drain32();
      int n = 0;
      while (q32.size() != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("drain32_left", 64'(q32.size()), 64'd0);
      @(posedge clk);
      #1;
      chk("drain32_valid", 64'(valid_out), 64'd0);
      chk("drain32_count", 64'(count_out), 64'd0);
   endtask

   task automatic drain8();
      int n = 0;
      while (q8.size() != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("drain8_left", 64'(q8.size()), 64'd0);
      @(posedge clk);
      #1;
      chk("drain8_valid", 64'(valid8_out), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_l = 1'b0; valid_in = 1'b0; ready_in = 1'b1; flush_in = 1'b0;
      ap = '0; a_in = '0; b_in = '0; tag_in = '0;
      rst8_l = 1'b0; valid8_in = 1'b0; ready8_in = 1'b1;
      flush8_in = 1'b0; ap8 = '0; a8_in = '0; b8_in = '0;
      tag8_in = '0;

      #12;
      chk("rst_ready", 64'(ready_out), 64'd0);
      chk("rst_valid", 64'(valid_out), 64'd0);
      chk("rst_result", 64'(result_out), 64'd0);
      chk("rst_error", 64'(error_out), 64'd0);
      chk("rst_tag", 64'(tag_out), 64'd0);
      chk("rst_count", 64'(count_out), 64'd0);
      @(negedge clk);
      rst_l = 1'b1; rst8_l = 1'b1;
      #1 chk("rel_ready_lo", 64'(ready_out), 64'd0);
      @(posedge clk);
      #1 chk("rel_ready_hi", 64'(ready_out), 64'd1);

      send32(mk_op(ADD), 32'h7FFF_FFFF, 32'd1, 4'd1, 32'h8000_0000, 1'b1);
      send32(mk_op(SUB), 32'h8000_0000, 32'd1, 4'd2, 32'h7FFF_FFFF, 1'b1);
      send32(mk_op(CLZ), 32'h0, 32'd0, 4'd3, 32'd32, 1'b0);
      send32(mk_op(CLZ), 32'h0001_0000, 32'd0, 4'd4, 32'd15, 1'b0);
      send32(mk_op(CPOP), 32'hF0F0_0000, 32'd0, 4'd5, 32'd8, 1'b0);
      send32(mk_op(ADD) | mk_op(SUB), 32'd5, 32'd3, 4'd6, 32'd0, 1'b1);
      send32('0, 32'd5, 32'd3, 4'd7, 32'd0, 1'b1);
      send32(mk_op(ADD), 32'd5, 32'd3, 4'd8, 32'd8, 1'b0);
      send32(mk_op(SUB), 32'd3, 32'd5, 4'd9, 32'hFFFF_FFFE, 1'b0);
      send32(mk_op(SLT), 32'hFFFF_FFFF, 32'd1, 4'd10, 32'd1, 1'b0);
      send32(mk_op(SLT), 32'd1, 32'hFFFF_FFFF, 4'd11, 32'd0, 1'b0);
      send32(mk_op(MIN), 32'hFFFF_FFFB, 32'd3, 4'd12, 32'hFFFF_FFFB, 1'b0);
      send32(mk_op(LAND), 32'hF0F0_00FF, 32'h0FF0_0F0F, 4'd13,
             32'h00F0_000F, 1'b0);
      send32(mk_op(LXOR), 32'hFFFF_0000, 32'h0F0F_0F0F, 4'd14,
             32'hF0F0_0F0F, 1'b0);
      send32(mk_op(SLL), 32'd1, 32'd35, 4'd15, 32'd8, 1'b0);
      send32(mk_op(SRA), 32'h8000_0000, 32'd4, 4'd0, 32'hF800_0000, 1'b0);
      send32(mk_op(ROL), 32'h8000_0001, 32'd4, 4'd1, 32'h0000_0018, 1'b0);
      send32(mk_op(ROL), 32'h1234_5678, 32'd0, 4'd2, 32'h1234_5678, 1'b0);
      send32(mk_op(BEXT), 32'h0000_0100, 32'd8, 4'd3, 32'd1, 1'b0);
      send32(mk_op(BEXT), 32'h0000_0100, 32'd9, 4'd4, 32'd0, 1'b0);
      drain32();

      ready_in = 1'b0;
      for (int k = 1; k <= 4; k++)
         send32(mk_op(ADD), 32'(k), 32'(k), 4'(k), 32'(2 * k), 1'b0);
      chk("bp_ready", 64'(ready_out), 64'd0);
      chk("bp_count", 64'(count_out), 64'd4);
      ap = mk_op(ADD); a_in = 32'd5; b_in = 32'd5; tag_in = 4'd5;
      valid_in = 1'b1;
      repeat (3) @(posedge clk);
      #1 valid_in = 1'b0;
      chk("bp_ready_hold", 64'(ready_out), 64'd0);
      chk("bp_count_hold", 64'(count_out), 64'd4);
      ready_in = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         chk("bp_valid", 64'(valid_out), 64'd1);
         chk("bp_order", 64'(tag_out), 64'(k));
      end
      drain32();

      ready_in = 1'b0;
      for (int k = 6; k <= 8; k++)
         send32(mk_op(ADD), 32'd1, 32'd1, 4'(k), 32'd2, 1'b0);
      chk("fl_count3", 64'(count_out), 64'd3);
      ap = mk_op(ADD); a_in = 32'd9; b_in = 32'd9; tag_in = 4'd9;
      valid_in = 1'b1; flush_in = 1'b1;
      @(posedge clk);
      #1 valid_in = 1'b0; flush_in = 1'b0;
      q32.delete();
      chk("fl_count", 64'(count_out), 64'd0);
      chk("fl_valid", 64'(valid_out), 64'd0);
      chk("fl_ready", 64'(ready_out), 64'd1);
      ready_in = 1'b1;
      send32(mk_op(ADD), 32'd10, 32'd10, 4'd10, 32'd20, 1'b0);
      drain32();

      send8(mk_op(SRA), 8'h80, 8'd3, 4'd1, 8'hF0, 1'b0);
      send8(mk_op(ROL), 8'h81, 8'd1, 4'd2, 8'h03, 1'b0);
      send8(mk_op(ADD), 8'h7F, 8'd1, 4'd3, 8'h80, 1'b1);
      send8(mk_op(CLZ), 8'h00, 8'd0, 4'd4, 8'd8, 1'b0);
      send8(mk_op(SLL), 8'h01, 8'd11, 4'd5, 8'h08, 1'b0);
      drain8();

      ready8_in = 1'b0;
      send8(mk_op(ADD), 8'd1, 8'd2, 4'd6, 8'd3, 1'b0);
      send8(mk_op(ADD), 8'd3, 8'd4, 4'd7, 8'd7, 1'b0);
      chk("r8_count2", 64'(count8_out), 64'd2);
      #2 rst8_l = 1'b0;
      #1;
      q8.delete();
      chk("r8_ready", 64'(ready8_out), 64'd0);
      chk("r8_valid", 64'(valid8_out), 64'd0);
      chk("r8_result", 64'(result8_out), 64'd0);
      chk("r8_error", 64'(error8_out), 64'd0);
      chk("r8_tag", 64'(tag8_out), 64'd0);
      chk("r8_count", 64'(count8_out), 64'd0);
      @(negedge clk);
      rst8_l = 1'b1;
      #1 chk("r8_rel_lo", 64'(ready8_out), 64'd0);
      @(posedge clk);
      #1;
      chk("r8_rel_hi", 64'(ready8_out), 64'd1);
      chk("r8_rel_cnt", 64'(count8_out), 64'd0);
      ready8_in = 1'b1;
      send8(mk_op(LXOR), 8'hAA, 8'hFF, 4'd8, 8'h55, 1'b0);
      drain8();

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/bmu_pipe.md
BMU_PIPE -- requirements
Module: bmu_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the operand/result width; legal values are 8, 16, 32 and 64.
REQ-002 SHALL have parameter DEPTH, default 4, giving the output FIFO entries; it is a power of two and at least 2.
REQ-003 SHALL have parameter TAG_W, default 4, giving the width of the transaction tag.
REQ-004 SHALL have one clock and an asynchronous active-low reset; ports: clk in 1 (clock); rst_l in 1 (reset).
REQ-005 SHALL have ports: valid_in in 1 (request valid); ready_out out 1 (request accepted when high with valid_in); ap in bmu_op_t (one-hot op select); a_in in WIDTH signed (operand 1); b_in in WIDTH signed (operand 2); tag_in in TAG_W (request tag).
REQ-006 SHALL have ports: valid_out out 1 (result valid); ready_in in 1 (consumer ready); result_out out WIDTH (result); error_out out 1 (error flag); tag_out out TAG_W (echoed tag); flush_in in 1 (synchronous pipeline clear); count_out out $clog2(DEPTH)+1 (FIFO occupancy).

Function
REQ-007 SHALL accept a request at a clk edge where valid_in & ready_out & !flush_in are all high.
REQ-008 SHALL compute an accepted request combinationally and write {result, error, tag} into the FIFO tail at the accepting edge, giving 1-cycle latency to valid_out when the FIFO is empty.
REQ-009 SHALL pop the FIFO head at a clk edge where valid_out & ready_in are high; result_out, error_out and tag_out reflect the head entry; valid_out = !empty.
REQ-010 SHALL drive ready_out from a register: 0 in reset; thereafter it equals !full as evaluated after the current edge's push and pop. There SHALL be no combinational path from ready_in to ready_out.
REQ-011 SHALL perform a simultaneous push and pop in one cycle with count unchanged; read and write pointers wrap modulo DEPTH.
REQ-012 SHALL implement these ops:
  - add, sub: wrap modulo 2^WIDTH.
  - slt, min: signed; slt returns 1 or 0.
  - land: a & b.
  - lxor: a ^ b.
  - sll, sra, rol: shift/rotate a by b[$clog2(WIDTH)-1:0].
  - clz: leading zeros of a; a==0 gives WIDTH.
  - cpop: number of set bits in a.
  - bext: a[b[$clog2(WIDTH)-1:0]], zero-extended.
REQ-013 SHALL set error to 1 on signed overflow of add or sub; the wrapped result is still returned.
REQ-014 SHALL set result to 0 and error to 1 when ap has zero bits set or more than one bit set.
REQ-015 SHALL, on flush_in high at an edge, empty the FIFO (count 0, valid_out 0 after the edge), drop any concurrent request, ignore any concurrent pop, and set ready_out to 1 after the edge.
REQ-016 SHALL keep count_out equal to the number of FIFO entries at all times.
REQ-017 SHALL hold the head entry stable while valid_out & !ready_in.

Reset
REQ-018 SHALL, while rst_l is low, force ready_out=0, valid_out=0, result_out=0, error_out=0, tag_out=0, count_out=0 and both pointers to 0, independent of clk.
REQ-019 SHALL discard in-flight entries when reset asserts mid-operation, and set ready_out to 1 at the first clk edge after rst_l rises.

Structure
REQ-020 SHALL take bmu_op_t (packed one-hot struct: add, sub, slt, min, land, lxor, sll, sra, rol, clz, cpop, bext) and the constant BMU_NUM_OPS=12 from the shared package bmu_pkg.
REQ-021 SHALL instantiate the FIFO as sub-module bmu_fifo, parametrised by entry width and DEPTH, with push, pop, flush, full, empty and count.
REQ-022 SHALL place the datapath in a function or always_comb block inside bmu_pipe, with no state in the datapath.

Verification
REQ-023 SHALL verify overflow (WIDTH=32): add, a=0x7FFFFFFF, b=1 -> result 0x80000000, error 1; sub, a=0x80000000, b=1 -> result 0x7FFFFFFF, error 1.
REQ-024 SHALL verify clz/cpop: clz a=0 -> 32; clz a=0x00010000 -> 15; cpop a=0xF0F00000 -> 8; all with error 0.
REQ-025 SHALL verify invalid op select: ap has add and sub both set, a=5, b=3 -> result 0, error 1, tag echoed.
REQ-026 SHALL verify backpressure: ready_in=0, DEPTH=4, issue 5 requests with tags 1-5 -> ready_out 0 after the 4th, count 4, tag 5 not accepted; raise ready_in -> tags 1,2,3,4 emerge in order on consecutive cycles.
REQ-027 SHALL verify flush: with 3 entries, assert flush_in together with valid_in -> count 0 and valid_out 0 next cycle, ready_out 1, the concurrent request is absent from later output.
REQ-028 SHALL verify WIDTH=8 and mid-operation reset:
  - sra a=0x80, b=3 -> 0xF0.
  - rol a=0x81, b=1 -> 0x03.
  - Assert rst_l low with 2 entries -> all outputs 0 immediately; ready_out 1 at the first edge after release.
